disaster_sample_scheduler: RTL and testbench

DISASTER_SAMPLE_SCHEDULER -- requirements
Module: disaster_sample_scheduler

---
 rtl/disaster_sample_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_disaster_sample_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/disaster_sample_scheduler.sv
// Round-robin sampler of four hazard sensors on one shared ADC; publishes coherent frames and a persistent-danger alarm.
// Frame latency >= 9 cycles after IDLE; WAIT stalls on adc_valid, bounded by TIMEOUT only when DSS_TIMEOUT_EN is defined.
module disaster_sample_scheduler #(
  parameter int FRAME_PERIOD = 1000,
  parameter int TIMEOUT      = 64,
  parameter int PERSIST      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       adc_start,
  output logic [1:0] adc_ch,
  input  logic       adc_valid,
  input  logic [6:0] adc_data,
  output logic [6:0] rain,
  output logic [4:0] seismic,
  output logic [6:0] wind,
  output logic [6:0] sea,
  output logic       frame_valid,
  input  logic       danger,
  output logic       alarm,
  input  logic       alarm_ack,
  output logic       fault,
  output logic [1:0] fault_ch
);

  localparam int PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int CW = $clog2(PERSIST + 1);

  if (FRAME_PERIOD < 1 || TIMEOUT < 1 || PERSIST < 1) begin : g_param_err
    $error("disaster_sample_scheduler: FRAME_PERIOD, TIMEOUT and PERSIST must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [PW-1:0]   period_q, period_d;
  logic [6:0]      rain_sh_q, rain_sh_d, wind_sh_q, wind_sh_d, sea_sh_q, sea_sh_d;
  logic [4:0]      seis_sh_q, seis_sh_d;
  logic [6:0]      rain_q, wind_q, sea_q;
  logic [4:0]      seis_q;
  logic [CW-1:0]   persist_q, persist_d;
  logic            alarm_q, alarm_d;
  logic            timeout_hit;
  logic            adv;
  logic            capture;
  logic            load_frame;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    period_d   = period_q;
    rain_sh_d  = rain_sh_q;
    seis_sh_d  = seis_sh_q;
    wind_sh_d  = wind_sh_q;
    sea_sh_d   = sea_sh_q;
    adv        = 1'b0;
    capture    = 1'b0;
    load_frame = 1'b0;
    case (state_q)
      S_IDLE: begin
        ch_d = 2'd0;
        if (!enable) begin
          period_d = '0;
        end else if (period_q == PW'(FRAME_PERIOD - 1)) begin
          period_d = '0;
          state_d  = S_ISSUE;
        end else begin
          period_d = period_q + PW'(1);
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        capture = adc_valid;
        adv     = adc_valid | timeout_hit;
        if (adv) begin
          if (ch_q == 2'd3) begin
            state_d    = S_DONE;
            load_frame = 1'b1;
          end else begin
            ch_d    = ch_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        ch_d    = 2'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      case (ch_q)
        2'd0:    rain_sh_d = adc_data;
        2'd1:    seis_sh_d = adc_data[6:2];
        2'd2:    wind_sh_d = adc_data;
        default: sea_sh_d  = adc_data;
      endcase
    end
  end

  // Ack dominates a coincident dangerous frame so the count restarts from zero.
  always_comb begin
    persist_d = persist_q;
    alarm_d   = alarm_q;
    if (alarm_ack) begin
      persist_d = '0;
      alarm_d   = 1'b0;
    end else if (state_q == S_DONE) begin
      if (!danger) begin
        persist_d = '0;
      end else if (persist_q != CW'(PERSIST)) begin
        persist_d = persist_q + CW'(1);
      end
      if (danger && (persist_d == CW'(PERSIST))) begin
        alarm_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= 2'd0;
      period_q  <= '0;
      rain_sh_q <= '0;
      seis_sh_q <= '0;
      wind_sh_q <= '0;
      sea_sh_q  <= '0;
      rain_q    <= '0;
      seis_q    <= '0;
      wind_q    <= '0;
      sea_q     <= '0;
      persist_q <= '0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      period_q  <= period_d;
      rain_sh_q <= rain_sh_d;
      seis_sh_q <= seis_sh_d;
      wind_sh_q <= wind_sh_d;
      sea_sh_q  <= sea_sh_d;
      persist_q <= persist_d;
      alarm_q   <= alarm_d;
      // Publish from the next-state shadows so the channel-3 sample lands in the same frame.
      if (load_frame) begin
        rain_q <= rain_sh_d;
        seis_q <= seis_sh_d;
        wind_q <= wind_sh_d;
        sea_q  <= sea_sh_d;
      end
    end
  end

`ifdef DSS_TIMEOUT_EN
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WW-1:0] wait_q, wait_d;
  logic          fault_q, fault_d;
  logic [1:0]    fault_ch_q, fault_ch_d;

  assign timeout_hit = (state_q == S_WAIT) && !adc_valid && (wait_q == WW'(TIMEOUT - 1));

  always_comb begin
    wait_d     = '0;
    fault_d    = fault_q | timeout_hit;
    fault_ch_d = fault_ch_q;
    if ((state_q == S_WAIT) && !adv) begin
      wait_d = wait_q + WW'(1);
    end
    if (timeout_hit) begin
      fault_ch_d = ch_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= '0;
      fault_q    <= 1'b0;
      fault_ch_q <= 2'd0;
    end else begin
      wait_q     <= wait_d;
      fault_q    <= fault_d;
      fault_ch_q <= fault_ch_d;
    end
  end

  assign fault    = fault_q;
  assign fault_ch = fault_ch_q;
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
  assign fault_ch    = 2'd0;
`endif

  assign adc_start   = (state_q == S_ISSUE);
  assign adc_ch      = ch_q;
  assign frame_valid = (state_q == S_DONE);
  assign rain        = rain_q;
  assign seismic     = seis_q;
  assign wind        = wind_q;
  assign sea         = sea_q;
  assign alarm       = alarm_q;

endmodule

// File: tb/tb_disaster_sample_scheduler.sv
// Bench for disaster_sample_scheduler: hand-computed frame table, hand-written corner sequences, randomized frames vs a frame-level model.
`timescale 1ns/1ps
module tb_disaster_sample_scheduler;

  localparam int FP  = 4;
  localparam int TMO = 64;
  localparam int PER = 3;

  logic       clk = 1'b0;
  logic       rst_n, enable, adc_start, adc_valid, frame_valid, danger, alarm, alarm_ack, fault;
  logic [1:0] adc_ch, fault_ch;
  logic [6:0] adc_data, rain, wind, sea;
  logic [4:0] seismic;

  int checks = 0;
  int errors = 0;

  logic [6:0] p_rain, p_wind, p_sea;
  logic [4:0] p_seis;
  int         m_cnt;
  bit         m_alarm, m_fault;
  logic [1:0] m_fault_ch;

  typedef struct {
    logic [3:0][6:0] d;
    int              lat;
    bit              dng;
    bit              ack;
    logic [25:0]     e_out;
    bit              e_alarm;
  } vec_t;
  vec_t tv[16];

  always #5 clk = ~clk;

  disaster_sample_scheduler #(.FRAME_PERIOD(FP), .TIMEOUT(TMO), .PERSIST(PER)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .adc_start(adc_start), .adc_ch(adc_ch), .adc_valid(adc_valid), .adc_data(adc_data),
    .rain(rain), .seismic(seismic), .wind(wind), .sea(sea), .frame_valid(frame_valid),
    .danger(danger), .alarm(alarm), .alarm_ack(alarm_ack), .fault(fault), .fault_ch(fault_ch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [25:0] outs();
    return {rain, seismic, wind, sea};
  endfunction

  task automatic set_vec(input int i, input int d0, input int d1, input int d2, input int d3,
                         input int lat, input bit dg, input bit ak,
                         input int er, input int es, input int ew, input int esea, input bit ea);
    tv[i].d       = {7'(d3), 7'(d2), 7'(d1), 7'(d0)};
    tv[i].lat     = lat;
    tv[i].dng     = dg;
    tv[i].ack     = ak;
    tv[i].e_out   = {7'(er), 5'(es), 7'(ew), 7'(esea)};
    tv[i].e_alarm = ea;
  endtask

  // Frame-level persistence rule: ack clears, danger counts up to PER, a safe frame restarts.
  task automatic model_step(input bit dng, input bit ack);
    if (ack) begin
      m_cnt   = 0;
      m_alarm = 1'b0;
    end else if (dng) begin
      if (m_cnt < PER) m_cnt++;
      if (m_cnt == PER) m_alarm = 1'b1;
    end else begin
      m_cnt = 0;
    end
  endtask

  // Runs one frame from IDLE: lat extra WAIT cycles before each valid, miss_ch never answered, enable dropped in drop_ch's WAIT.
  task automatic do_frame(input logic [3:0][6:0] d, input int lat, input int miss_ch, input int drop_ch,
                          input bit dng, input bit ack, input logic [25:0] e_out, input bit e_alarm,
                          input int idle_exp);
    int n;
    int cyc;
    int nw;
    int exp_cyc;
    n = 0;
    while (adc_start !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk("frame_start", adc_start, 1);
    chk("idle_gap", n, idle_exp);
    cyc     = 0;
    exp_cyc = 0;
    for (int ch = 0; ch < 4; ch++) begin
      chk("issue_start", adc_start, 1);
      chk("issue_ch", adc_ch, ch);
      chk("issue_no_fv", frame_valid, 0);
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = 7'($urandom);
      tick();
      cyc++;
      adc_valid = 1'b0;
      if (ch == drop_ch) enable = 1'b0;
      nw = (ch == miss_ch) ? TMO : lat + 1;
      exp_cyc += 1 + nw;
      for (int w = 0; w < nw; w++) begin
        chk("wait_ch", adc_ch, ch);
        chk("wait_no_start", adc_start, 0);
        chk("wait_hold", outs(), {p_rain, p_seis, p_wind, p_sea});
        if (ch != miss_ch && w == nw - 1) begin
          adc_valid = 1'b1;
          adc_data  = d[ch];
        end
        tick();
        cyc++;
        adc_valid = 1'b0;
        adc_data  = 7'($urandom);
      end
    end
    chk("done_fv", frame_valid, 1);
    // With no extra latency this is 8 edges, i.e. frame_valid in the 9th cycle after leaving IDLE.
    chk("frame_latency", cyc, exp_cyc);
    chk("frame_outs", outs(), e_out);
    chk("fault", {fault, fault_ch}, {m_fault, m_fault_ch});
    danger    = dng;
    alarm_ack = ack;
    adc_valid = 1'($urandom_range(0, 1));
    adc_data  = 7'($urandom);
    tick();
    adc_valid = 1'b0;
    alarm_ack = 1'b0;
    danger    = 1'($urandom_range(0, 1));
    chk("fv_one_cycle", frame_valid, 0);
    chk("alarm", alarm, e_alarm);
    chk("outs_stable", outs(), e_out);
    {p_rain, p_seis, p_wind, p_sea} = e_out;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int              n;
    logic [3:0][6:0] dv;
    int              lat;
    bit              dg, ak;

    rst_n = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = '0; danger = 1'b0; alarm_ack = 1'b0;
    p_rain = '0; p_seis = '0; p_wind = '0; p_sea = '0;
    m_cnt = 0; m_alarm = 1'b0; m_fault = 1'b0; m_fault_ch = 2'd0;

    //          d0   d1   d2   d3 lat dg ak   rain seis wind sea alarm
    set_vec( 0,  25,  63,  40,  55, 2, 0, 0,   25, 15,  40,  55, 0);
    set_vec( 1,   1,   2,   3,   4, 0, 1, 0,    1,  0,   3,   4, 0);
    set_vec( 2, 127, 127, 127, 127, 1, 1, 0,  127, 31, 127, 127, 0);
    set_vec( 3,  10,  20,  30,  40, 0, 0, 0,   10,  5,  30,  40, 0);
    set_vec( 4,   5,   6,   7,   8, 3, 1, 0,    5,  1,   7,   8, 0);
    set_vec( 5,   0,   0,   0,   0, 0, 1, 0,    0,  0,   0,   0, 0);
    set_vec( 6, 100, 101, 102, 103, 0, 1, 0,  100, 25, 102, 103, 1);
    set_vec( 7,   9,   9,   9,   9, 0, 0, 0,    9,  2,   9,   9, 1);
    set_vec( 8,  11,  12,  13,  14, 1, 1, 0,   11,  3,  13,  14, 1);
    set_vec( 9,  21,  22,  23,  24, 0, 1, 0,   21,  5,  23,  24, 1);
    set_vec(10,  31,  32,  33,  34, 0, 1, 0,   31,  8,  33,  34, 1);
    set_vec(11,  41,  42,  43,  44, 0, 1, 1,   41, 10,  43,  44, 0);
    set_vec(12,  51,  52,  53,  54, 0, 1, 0,   51, 13,  53,  54, 0);
    set_vec(13,  61,  62,  63,  64, 0, 1, 0,   61, 15,  63,  64, 0);
    set_vec(14,  71,  72,  73,  74, 0, 1, 0,   71, 18,  73,  74, 1);
    set_vec(15,  81,  82,  83,  84, 0, 0, 0,   81, 20,  83,  84, 1);

    repeat (3) tick();
    chk("rst_ctl", {adc_start, adc_ch, frame_valid, alarm, fault, fault_ch}, 0);
    chk("rst_outs", outs(), 0);
    rst_n  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_frame(tv[i].d, tv[i].lat, -1, -1, tv[i].dng, tv[i].ack, tv[i].e_out, tv[i].e_alarm, FP);
    end

    // Enable falls in channel 1's WAIT: frame finishes, then the scheduler stays idle.
    do_frame({7'd4, 7'd3, 7'd2, 7'd1}, 1, -1, 1, 1'b0, 1'b0, {7'd1, 5'd0, 7'd3, 7'd4}, 1'b1, FP);
    n = 0;
    for (int i = 0; i < 3 * FP; i++) begin
      if (adc_start === 1'b1 || frame_valid === 1'b1) n++;
      tick();
    end
    chk("drop_no_restart", n, 0);
    enable = 1'b1;

    // Reset asserted in channel 1's WAIT abandons the frame.
    n = 0;
    while (adc_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_seq_gap", n, FP);
    tick();
    adc_valid = 1'b1;
    adc_data  = 7'd77;
    tick();
    adc_valid = 1'b0;
    tick();
    chk("rst_seq_wait_ch", adc_ch, 1);
    chk("pre_rst_alarm", alarm, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {adc_start, adc_ch, frame_valid, alarm, fault, fault_ch}, 0);
    chk("rst_async_outs", outs(), 0);
    n = 0;
    repeat (6) begin
      adc_valid = 1'($urandom_range(0, 1));
      tick();
      if (frame_valid !== 1'b0 || adc_start !== 1'b0) n++;
    end
    adc_valid = 1'b0;
    chk("rst_no_activity", n, 0);
    rst_n = 1'b1;
    p_rain = '0; p_seis = '0; p_wind = '0; p_sea = '0;
    m_cnt = 0; m_alarm = 1'b0; m_fault = 1'b0; m_fault_ch = 2'd0;

    for (int i = 0; i < 30; i++) begin
      dv  = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
      lat = $urandom_range(0, 3);
      dg  = ($urandom_range(0, 3) != 0);
      ak  = ($urandom_range(0, 7) == 0);
      model_step(dg, ak);
      do_frame(dv, lat, -1, -1, dg, ak, {dv[0], dv[1][6:2], dv[2], dv[3]}, m_alarm, FP);
    end

`ifdef DSS_TIMEOUT_EN
    dv = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
    m_fault = 1'b1; m_fault_ch = 2'd2;
    model_step(1'b1, 1'b0);
    do_frame(dv, 1, 2, -1, 1'b1, 1'b0, {dv[0], dv[1][6:2], p_wind, dv[3]}, m_alarm, FP);
    dv = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
    m_fault_ch = 2'd1;
    model_step(1'b0, 1'b0);
    do_frame(dv, 0, 1, -1, 1'b0, 1'b0, {dv[0], p_seis, dv[2], dv[3]}, m_alarm, FP);
`else
    // Without the timeout feature a long silent WAIT simply stalls.
    dv = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
    model_step(1'b0, 1'b0);
    do_frame(dv, TMO + 36, -1, -1, 1'b0, 1'b0, {dv[0], dv[1][6:2], dv[2], dv[3]}, m_alarm, FP);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
